iomem_i2s_tx: RTL and testbench
===============================

Name: iomem_i2s_tx

Overview:
Memory-mapped audio output peripheral on the picosoc iomem bus, decoded at prefix 0x04 beside the GPIO block at 0x03. Firmware writes packed 16-bit stereo samples into a FIFO. The block drains the FIFO to the codec as a master-mode Philips I2S stream (BCLK, LRCLK, SDATA) with a programmable BCLK divider. A level interrupt goes to picosoc irq_5.

Parameters:
ADDR_PREFIX, 8'h04, iomem_addr[31:24] value that selects this block
FIFO_AW, 4, log2 of FIFO depth (default 16 entries x 32 bits)
DIV_DEFAULT, 8'd2, reset value of CLKDIV

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
iomem_valid  in  1  bus request
iomem_ready  out  1  one-cycle acknowledge
iomem_wstrb  in  4  byte write strobes; 0 = read
iomem_addr  in  32  byte address
iomem_wdata  in  32  write data
iomem_rdata  out  32  read data, valid while iomem_ready=1
i2s_bclk  out  1  bit clock
i2s_lrclk  out  1  word select; 0 = left
i2s_sdata  out  1  serial data, MSB first
irq  out  1  FIFO low-water interrupt, level

Behaviour:
- Reset (resetn=0 at a clk edge): all outputs 0, FIFO empty, CTRL=0, CLKDIV=DIV_DEFAULT, sticky flags 0, divider and slot counters 0.
- Selection: iomem_valid && !iomem_ready && iomem_addr[31:24]==ADDR_PREFIX. iomem_ready=1 for exactly one cycle, the cycle after selection. iomem_ready is 0 in every other cycle. Unselected requests are ignored.
- Register map, addr[3:2]:
  - 0 DATA: write with wstrb=4'hF pushes {L[31:16],R[15:0]}. Any other nonzero strobe is ignored. Reads return 0.
  - 1 STATUS (RO): [7:0]=level, [8]=empty, [9]=full, [10]=underrun, [11]=overflow.
  - 2 CTRL: [0]=enable, [1]=irq_en. Writing 1 to bit [8] clears both sticky flags. Only wstrb[0] and wstrb[1] lanes apply.
  - 3 CLKDIV: [7:0], writable via wstrb[0]. A value of 0 is treated as 1.
- FIFO: synchronous, depth 2^FIFO_AW.
  - A push while full is dropped and sets overflow, even if a pop occurs in the same cycle.
  - A simultaneous accepted push and pop leaves level unchanged.
  - Pointers wrap modulo depth.
- Clocking, while enable=1:
  - The divider counts clk cycles from 0 to CLKDIV-1.
  - i2s_bclk toggles on the cycle the count wraps, so f_bclk = f_clk / (2*CLKDIV).
  - Each falling BCLK edge advances slot counter s, 0..31, wrapping.
  - i2s_lrclk = s[4], updated on that same falling edge.
- Data path (Philips I2S, 16-bit slots):
  - On the falling edge entering s=1, a 32-bit shift register loads the FIFO head and pops it, and i2s_sdata = bit31 (L MSB).
  - Each subsequent falling edge shifts left. The R LSB therefore appears in s=0 of the next frame.
  - Outputs change only on falling edges. The codec samples on rising edges.
- Underrun: if the FIFO is empty at the s=1 load, the block loads 0, sets the underrun flag, and does not pop.
- Disable (enable 1->0): on the next clk, bclk, lrclk and sdata go to 0 and the divider, slot counter and shift register clear. FIFO contents and flags are kept.
- Enable 0->1: the first falling edge enters s=1, so a frame load happens at once.
- CLKDIV write mid-stream: the new value takes effect at the next divider wrap. No glitch is allowed shorter than min(old, new) clk cycles.
- irq = irq_en && (level <= 2^(FIFO_AW-1)), registered.
- Reset mid-frame: all state returns to the reset values on that edge. There is no partial-frame completion.

Decomposition:
- Package i2s_tx_pkg holds:
  - register offsets REG_DATA, REG_STATUS, REG_CTRL, REG_CLKDIV;
  - STATUS and CTRL bit positions;
  - SLOT_BITS=16 and FRAME_SLOTS=32.
- Sub-module sync_fifo (params WIDTH, AW): ports push, pop, wdata, rdata (head, show-ahead), level, full, empty.
- The top holds bus decode, registers, BCLK divider, slot counter and shifter.

Test Plan:
- Reset defaults: after reset, read 0x04000004 -> 0x00000100, read 0x0400000C -> 0x00000002, and bclk/lrclk/sdata/irq all 0.
- Bus handshake: hold valid to 0x04000004 for 4 cycles -> ready high exactly in cycle 2 (one cycle after selection), low otherwise. Valid to 0x05000000 -> ready never asserts.
- Serial frame: CLKDIV=2, push 0xA5C3_0F81, enable -> bclk period 4 clk. On bclk rising edges in s=1..16 sdata reads 1010010111000011. In s=17..31 and s=0 it reads 0000111110000001. lrclk=0 for s=0..15.
- Underrun: enable with empty FIFO -> sdata stays 0 and STATUS[10]=1 after the first load. Write CTRL 0x101 -> flag clears and enable stays 1.
- Overflow/full: push 17 words with depth 16 -> level=16, full=1, overflow=1, and the 17th word is never transmitted. A partial-strobe DATA write (wstrb=4'h3) -> level unchanged.
- IRQ and wrap: irq_en=1, push 16 words, then stream -> irq rises when level reaches 8. Push 20 more over time -> data order is preserved across pointer wrap.

Source files
------------

// File: rtl/i2s_tx_pkg.sv
// Shared register map, bit positions and frame geometry for the iomem I2S transmitter.
package i2s_tx_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_CLKDIV = 2'd3;

   localparam int unsigned ST_EMPTY    = 8;
   localparam int unsigned ST_FULL     = 9;
   localparam int unsigned ST_UNDERRUN = 10;
   localparam int unsigned ST_OVERFLOW = 11;

   localparam int unsigned CTRL_EN     = 0;
   localparam int unsigned CTRL_IRQ_EN = 1;
   localparam int unsigned CTRL_CLR    = 8;

   localparam int unsigned SLOT_BITS   = 16;
   localparam int unsigned FRAME_SLOTS = 32;
   localparam int unsigned FRAME_BITS  = 2 * SLOT_BITS;
   localparam int unsigned SLOT_W      = $clog2(FRAME_SLOTS);

   // A programmed divider of 0 behaves as 1.
   function automatic logic [7:0] div_eff(input logic [7:0] d);
      return (d == 8'd0) ? 8'd1 : d;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; pushes while full and pops while empty are ignored.
module sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned AW    = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [AW:0]      level,
   output logic             full,
   output logic             empty
);

   localparam int unsigned DEPTH    = 1 << AW;
   localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full    = (count_q == FULL_LVL);
   assign empty   = (count_q == '0);
   assign level   = count_q;
   assign rdata   = mem[rptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr_q] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            wptr_q <= wptr_q + 1'b1;
         end
         if (do_pop) begin
            rptr_q <= rptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/iomem_i2s_tx.sv
// picosoc iomem peripheral: sample FIFO drained as a master-mode Philips I2S stream.
module iomem_i2s_tx
   import i2s_tx_pkg::*;
#(
   parameter logic [7:0]  ADDR_PREFIX = 8'h04,
   parameter int unsigned FIFO_AW     = 4,
   parameter logic [7:0]  DIV_DEFAULT = 8'd2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        iomem_valid,
   output logic        iomem_ready,
   input  logic [3:0]  iomem_wstrb,
   input  logic [31:0] iomem_addr,
   input  logic [31:0] iomem_wdata,
   output logic [31:0] iomem_rdata,
   output logic        i2s_bclk,
   output logic        i2s_lrclk,
   output logic        i2s_sdata,
   output logic        irq
);

   localparam logic [FIFO_AW:0] LOW_WATER = {2'b01, {(FIFO_AW - 1){1'b0}}};

   logic                  ready_q, irq_q;
   logic [31:0]           rdata_q, rd_mux;
   logic                  enable_q, irq_en_q, underrun_q, overflow_q;
   logic [7:0]            div_q, div_act_q, cnt_q;
   logic                  bclk_q, lrclk_q, sdata_q;
   logic [SLOT_W-1:0]     slot_q, slot_nxt;
   logic [FRAME_BITS-1:0] shreg_q, load_word;

   logic                  sel, is_read, data_push, ctrl_wr, ctrl_clr, div_wr;
   logic                  wrap, fall, load;
   logic                  fifo_pop, fifo_full, fifo_empty;
   logic [31:0]           fifo_rdata;
   logic [FIFO_AW:0]      fifo_level;
   logic                  unused_addr;

   assign unused_addr = ^{iomem_addr[23:4], iomem_addr[1:0]};

   assign sel       = iomem_valid && !ready_q && (iomem_addr[31:24] == ADDR_PREFIX);
   assign is_read   = sel && (iomem_wstrb == 4'h0);
   assign data_push = sel && (iomem_addr[3:2] == REG_DATA) && (iomem_wstrb == 4'hF);
   assign ctrl_wr   = sel && (iomem_addr[3:2] == REG_CTRL) && iomem_wstrb[0];
   assign ctrl_clr  = sel && (iomem_addr[3:2] == REG_CTRL) && iomem_wstrb[1]
                      && iomem_wdata[CTRL_CLR];
   assign div_wr    = sel && (iomem_addr[3:2] == REG_CLKDIV) && iomem_wstrb[0];

   // Half-period of BCLK ends when the counter reaches the latched divider.
   assign wrap      = enable_q && (cnt_q == div_act_q - 8'd1);
   assign fall      = wrap && bclk_q;
   assign slot_nxt  = slot_q + 1'b1;
   assign load      = fall && (slot_nxt == SLOT_W'(1));
   assign fifo_pop  = load && !fifo_empty;
   assign load_word = fifo_empty ? '0 : fifo_rdata;

   sync_fifo #(
      .WIDTH (32),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (data_push),
      .pop    (fifo_pop),
      .wdata  (iomem_wdata),
      .rdata  (fifo_rdata),
      .level  (fifo_level),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   always_comb begin
      rd_mux = '0;
      case (iomem_addr[3:2])
         REG_STATUS: begin
            rd_mux[7:0]         = 8'(fifo_level);
            rd_mux[ST_EMPTY]    = fifo_empty;
            rd_mux[ST_FULL]     = fifo_full;
            rd_mux[ST_UNDERRUN] = underrun_q;
            rd_mux[ST_OVERFLOW] = overflow_q;
         end
         REG_CTRL: begin
            rd_mux[CTRL_EN]     = enable_q;
            rd_mux[CTRL_IRQ_EN] = irq_en_q;
         end
         REG_CLKDIV: rd_mux[7:0] = div_q;
         default:    rd_mux      = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         ready_q    <= 1'b0;
         rdata_q    <= '0;
         irq_q      <= 1'b0;
         enable_q   <= 1'b0;
         irq_en_q   <= 1'b0;
         underrun_q <= 1'b0;
         overflow_q <= 1'b0;
         div_q      <= DIV_DEFAULT;
      end else begin
         ready_q <= sel;
         rdata_q <= is_read ? rd_mux : '0;
         irq_q   <= irq_en_q && (fifo_level <= LOW_WATER);
         if (ctrl_wr) begin
            enable_q <= iomem_wdata[CTRL_EN];
            irq_en_q <= iomem_wdata[CTRL_IRQ_EN];
         end
         if (div_wr) begin
            div_q <= iomem_wdata[7:0];
         end
         // A flag event in the same cycle as a clear survives the clear.
         underrun_q <= (underrun_q && !ctrl_clr) || (load && fifo_empty);
         overflow_q <= (overflow_q && !ctrl_clr) || (data_push && fifo_full);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         div_act_q <= div_eff(DIV_DEFAULT);
         cnt_q     <= '0;
         bclk_q    <= 1'b0;
         lrclk_q   <= 1'b0;
         sdata_q   <= 1'b0;
         slot_q    <= '0;
         shreg_q   <= '0;
      end else if (!enable_q) begin
         div_act_q <= div_eff(div_q);
         cnt_q     <= '0;
         bclk_q    <= 1'b0;
         lrclk_q   <= 1'b0;
         sdata_q   <= 1'b0;
         slot_q    <= '0;
         shreg_q   <= '0;
      end else if (wrap) begin
         cnt_q     <= '0;
         div_act_q <= div_eff(div_q);
         bclk_q    <= !bclk_q;
         if (fall) begin
            slot_q  <= slot_nxt;
            lrclk_q <= slot_nxt[SLOT_W-1];
            if (load) begin
               shreg_q <= load_word;
               sdata_q <= load_word[FRAME_BITS-1];
            end else begin
               shreg_q <= {shreg_q[FRAME_BITS-2:0], 1'b0};
               sdata_q <= shreg_q[FRAME_BITS-2];
            end
         end
      end else begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

   assign iomem_ready = ready_q;
   assign iomem_rdata = rdata_q;
   assign i2s_bclk    = bclk_q;
   assign i2s_lrclk   = lrclk_q;
   assign i2s_sdata   = sdata_q;
   assign irq         = irq_q;

endmodule

// File: tb/tb_iomem_i2s_tx.sv
// Randomised bench for iomem_i2s_tx against a queue-based cycle model of the peripheral.
module tb_iomem_i2s_tx;

   logic        clk = 1'b0;
   logic        resetn;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;
   logic        i2s_bclk, i2s_lrclk, i2s_sdata, irq;

   int total = 0;
   int bad   = 0;

   always #5 clk = !clk;

   iomem_i2s_tx dut (
      .clk         (clk),
      .resetn      (resetn),
      .iomem_valid (iomem_valid),
      .iomem_ready (iomem_ready),
      .iomem_wstrb (iomem_wstrb),
      .iomem_addr  (iomem_addr),
      .iomem_wdata (iomem_wdata),
      .iomem_rdata (iomem_rdata),
      .i2s_bclk    (i2s_bclk),
      .i2s_lrclk   (i2s_lrclk),
      .i2s_sdata   (i2s_sdata),
      .irq         (irq)
   );

   function automatic void chk(input string name, input logic [31:0] got,
                               input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
      end
   endfunction

   // ---------------- behavioural model ----------------
   logic [31:0] mq[$];
   bit          live = 0;
   bit          m_ready, m_bclk, m_lr, m_sdata, m_irq, m_en, m_irqen, m_unf, m_ovf;
   logic [31:0] m_rdata, m_word;
   logic [7:0]  m_div;
   int          m_left, m_s;

   always @(posedge clk) begin
      int          lvl, eff;
      bit          sel, was_full, set_unf, set_ovf, clr;
      logic [31:0] rd;
      live = 1;
      if (!resetn) begin
         mq.delete();
         {m_ready, m_bclk, m_lr, m_sdata, m_irq, m_en, m_irqen, m_unf, m_ovf} = '0;
         m_rdata = 0; m_word = 0; m_div = 8'd2; m_left = 2; m_s = 0;
      end else begin
         lvl      = mq.size();
         was_full = (lvl == 16);
         eff      = (m_div == 0) ? 1 : int'(m_div);
         sel      = iomem_valid && !m_ready && (iomem_addr[31:24] == 8'h04);
         rd       = 0;
         if (sel && iomem_wstrb == 0) begin
            case (iomem_addr[3:2])
               2'd1: rd = {20'd0, m_ovf, m_unf, was_full, lvl == 0, 8'(lvl)};
               2'd2: rd = {30'd0, m_irqen, m_en};
               2'd3: rd = {24'd0, m_div};
               default: rd = 0;
            endcase
         end
         m_irq   = m_irqen && (lvl <= 8);
         set_unf = 0;
         set_ovf = 0;
         if (!m_en) begin
            m_left = eff; m_bclk = 0; m_s = 0; m_word = 0; m_sdata = 0; m_lr = 0;
         end else begin
            m_left--;
            if (m_left == 0) begin
               m_left = eff;
               if (m_bclk) begin
                  m_s = (m_s + 1) % 32;
                  if (m_s == 1) begin
                     if (lvl == 0) begin m_word = 0; set_unf = 1; end
                     else m_word = mq.pop_front();
                  end
                  m_sdata = m_word[(32 - m_s) % 32];
                  m_lr    = (m_s >= 16);
               end
               m_bclk = !m_bclk;
            end
         end
         clr = 0;
         if (sel && iomem_addr[3:2] == 2'd0 && iomem_wstrb == 4'hF) begin
            if (was_full) set_ovf = 1;
            else mq.push_back(iomem_wdata);
         end
         if (sel && iomem_addr[3:2] == 2'd2) begin
            if (iomem_wstrb[0]) {m_irqen, m_en} = iomem_wdata[1:0];
            clr = iomem_wstrb[1] && iomem_wdata[8];
         end
         if (sel && iomem_addr[3:2] == 2'd3 && iomem_wstrb[0]) m_div = iomem_wdata[7:0];
         if (clr) begin m_unf = 0; m_ovf = 0; end
         if (set_unf) m_unf = 1;
         if (set_ovf) m_ovf = 1;
         m_ready = sel;
         m_rdata = rd;
      end
   end

   always @(negedge clk) begin
      if (live) begin
         chk("ready", iomem_ready, m_ready);
         chk("rdata", iomem_rdata, m_rdata);
         chk("bclk",  i2s_bclk,    m_bclk);
         chk("lrclk", i2s_lrclk,   m_lr);
         chk("sdata", i2s_sdata,   m_sdata);
         chk("irq",   irq,         m_irq);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                      output logic [31:0] r);
      int n;
      @(negedge clk);
      iomem_valid = 1; iomem_addr = a; iomem_wstrb = s; iomem_wdata = d;
      n = 0;
      do begin @(negedge clk); n++; end while (!iomem_ready && n < 8);
      chk("bus_ready_seen", iomem_ready, 1);
      r = iomem_rdata;
      iomem_valid = 0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
      logic [31:0] r;
      bus(a, s, d, r);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic wait_rise(output int n);
      logic p;
      bit   seen;
      p = i2s_bclk; n = 0; seen = 0;
      while (!seen && n < 400) begin
         @(negedge clk);
         n++;
         if (i2s_bclk && !p) seen = 1;
         p = i2s_bclk;
      end
      chk("bclk_rise_seen", 32'(seen), 1);
   endtask

   localparam logic [31:0] STAT = 32'h0400_0004;
   localparam logic [31:0] CTRL = 32'h0400_0008;
   localparam logic [31:0] DIVR = 32'h0400_000C;
   localparam logic [31:0] DATA = 32'h0400_0000;

   initial begin
      logic [31:0] r, word, lrv;
      int          n;
      resetn = 0; iomem_valid = 0; iomem_addr = 0; iomem_wstrb = 0; iomem_wdata = 0;
      idle(3);
      resetn = 1;
      chk("rst_outs", {28'd0, i2s_bclk, i2s_lrclk, i2s_sdata, irq}, 0);
      bus(STAT, 4'h0, 0, r); chk("rst_status", r, 32'h0000_0100);
      bus(DIVR, 4'h0, 0, r); chk("rst_clkdiv", r, 32'h0000_0002);
      bus(CTRL, 4'h0, 0, r); chk("rst_ctrl", r, 32'h0000_0000);

      // Handshake: ready exactly in the cycle after selection.
      @(negedge clk);
      iomem_valid = 1; iomem_addr = STAT; iomem_wstrb = 0;
      chk("hs_c1", iomem_ready, 0);
      @(negedge clk); chk("hs_c2", iomem_ready, 1); iomem_valid = 0;
      @(negedge clk); chk("hs_c3", iomem_ready, 0);
      @(negedge clk); chk("hs_c4", iomem_ready, 0);
      iomem_valid = 1; iomem_addr = 32'h0500_0000;
      for (int i = 0; i < 4; i++) begin @(negedge clk); chk("unsel_ready", iomem_ready, 0); end
      iomem_valid = 0;

      // Serial frame.
      wr(DIVR, 4'h1, 2);
      wr(DATA, 4'hF, 32'hA5C3_0F81);
      wr(CTRL, 4'h1, 1);
      wait_rise(n);
      for (int k = 0; k < 32; k++) begin
         wait_rise(n);
         chk("bclk_period", n, 4);
         word[31-k] = i2s_sdata;
         lrv[31-k]  = i2s_lrclk;
      end
      chk("frame_sdata", word, 32'hA5C3_0F81);
      chk("frame_lrclk", lrv, 32'h0001_FFFE);

      // Underrun.
      wr(CTRL, 4'h3, 32'h100);
      idle(2);
      chk("dis_outs", {29'd0, i2s_bclk, i2s_lrclk, i2s_sdata}, 0);
      wr(CTRL, 4'h1, 1);
      idle(8);
      bus(STAT, 4'h0, 0, r); chk("unf_status", r, 32'h0000_0500);
      wr(CTRL, 4'h3, 32'h101);
      bus(STAT, 4'h0, 0, r); chk("unf_cleared", r, 32'h0000_0100);
      bus(CTRL, 4'h0, 0, r); chk("unf_ctrl", r, 32'h0000_0001);

      // Overflow / full.
      wr(CTRL, 4'h3, 32'h100);
      wr(DIVR, 4'h1, 1);
      for (int i = 0; i < 17; i++) wr(DATA, 4'hF, $urandom);
      bus(STAT, 4'h0, 0, r); chk("ovf_status", r, 32'h0000_0A10);
      wr(DATA, 4'h3, 32'hDEAD_BEEF);
      bus(STAT, 4'h0, 0, r); chk("partial_strobe", r, 32'h0000_0A10);

      // IRQ and pointer wrap.
      wr(CTRL, 4'h1, 2);
      idle(2);
      chk("irq_full_low", irq, 0);
      wr(CTRL, 4'h1, 3);
      n = 0;
      while (!irq && n < 3000) begin @(negedge clk); n++; end
      chk("irq_rise", irq, 1);
      bus(STAT, 4'h0, 0, r); chk("irq_level", r, 32'h0000_0808);
      for (int i = 0; i < 20; i++) begin
         idle($urandom_range(55, 70));
         wr(DATA, 4'hF, $urandom);
      end
      idle(1500);

      // Reset mid-frame.
      wr(CTRL, 4'h1, 1);
      wr(DATA, 4'hF, $urandom);
      idle(37);
      @(negedge clk); resetn = 0;
      @(negedge clk); resetn = 1;
      bus(STAT, 4'h0, 0, r); chk("midrst_status", r, 32'h0000_0100);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         logic [3:0]  s;
         logic [1:0]  off;
         logic [31:0] d;
         off = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 4))
            0: s = 4'h0; 1: s = 4'hF; 2: s = 4'h3; 3: s = 4'h1; default: s = 4'h2;
         endcase
         d = $urandom;
         if (off == 2'd3) d = 32'($urandom_range(0, 3));
         if (off == 2'd2 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
         if ($urandom_range(0, 9) == 0) begin
            @(negedge clk);
            iomem_valid = 1; iomem_addr = {8'h07, 22'd0, off, 2'b00}; iomem_wstrb = s;
            idle(2);
            iomem_valid = 0;
         end else begin
            bus({8'h04, 20'd0, off, 2'b00}, s, d, r);
         end
         idle($urandom_range(0, 12));
      end
      idle(200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
